spi_receiver: RTL



---
 rtl/config_pkg.sv | 32 +++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_receiver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
`timescale 1ns/1ps
// Shared SPI configuration: word width, mode encoding and receiver state type.
package config_pkg;

  localparam int P_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  function automatic logic mode_cpol(input spi_mode_t mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_t mode);
    return mode[0];
  endfunction

  // Modes 0 and 3 sample on rising sck, modes 1 and 2 on falling sck.
  function automatic logic mode_sample_rise(input spi_mode_t mode);
    return mode_cpol(mode) == mode_cpha(mode);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
// Multi-flop synchronizer with a history flop; emits registered rise/fall
// pulses that are cycle-aligned with the level output.
module spi_sync_edge #(
  parameter int   P_SYNC_STAGES = 2,
  parameter logic P_IDLE        = 1'b0
) (
  input  logic clk_100,
  input  logic s_rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [P_SYNC_STAGES-1:0] sync_q;

  // Synchronize the pin, remember the previous synced value, flag transitions.
  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      sync_q <= {P_SYNC_STAGES{P_IDLE}};
      level  <= P_IDLE;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[P_SYNC_STAGES-2:0], din};
      level  <= sync_q[P_SYNC_STAGES-1];
      rise   <= sync_q[P_SYNC_STAGES-1] & ~level;
      fall   <= ~sync_q[P_SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/spi_receiver.sv
`timescale 1ns/1ps
// SPI receive stage: oversamples sck/cs/mosi on clk_100, deserializes MSB-first
// words and hands them out through a one-word valid/ready holding register.
//
//   state | meaning
//   IDLE  | waiting for cs to fall; sck edges ignored
//   RECV  | cs active, shifting mosi on each sample edge
module spi_receiver
  import config_pkg::*;
#(
  parameter int P_DATA_WIDTH  = config_pkg::P_DATA_WIDTH,
  parameter int P_MODE        = 0,
  parameter int P_SYNC_STAGES = 2
) (
  input  logic                    clk_100,
  input  logic                    s_rst,
  input  logic                    sck,
  input  logic                    cs,
  input  logic                    mosi,
  output logic [P_DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic                    frame_err
);

  localparam int        CNT_W       = $clog2(P_DATA_WIDTH) + 1;
  localparam spi_mode_t MODE        = spi_mode_t'(P_MODE[1:0]);
  localparam logic      SCK_IDLE    = mode_cpol(MODE);
  localparam logic      SAMPLE_HIGH = mode_sample_rise(MODE);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [P_SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_lvl;
  logic sample;

  logic [P_SYNC_STAGES:0] flush_sr;
  logic cs_armed;

  rx_state_t state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [P_DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic commit, ferr_nxt;

  spi_sync_edge #(.P_SYNC_STAGES(P_SYNC_STAGES), .P_IDLE(SCK_IDLE)) u_sck_sync (
    .clk_100 (clk_100),
    .s_rst   (s_rst),
    .din     (sck),
    .level   (sck_lvl),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  spi_sync_edge #(.P_SYNC_STAGES(P_SYNC_STAGES), .P_IDLE(1'b1)) u_cs_sync (
    .clk_100 (clk_100),
    .s_rst   (s_rst),
    .din     (cs),
    .level   (cs_lvl),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  // A sample edge is an sck transition that lands on the mode's sample level.
  assign sample = (sck_rise | sck_fall) & (sck_lvl == SAMPLE_HIGH);

  // mosi synchronizer plus one flop so it lines up with the sck edge pulses.
  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      mosi_sync_q <= '0;
      mosi_lvl    <= 1'b0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[P_SYNC_STAGES-2:0], mosi};
      mosi_lvl    <= mosi_sync_q[P_SYNC_STAGES-1];
    end
  end

  // After reset the sync chain holds idle values, not the pin; a frame already
  // underway must not look like a fresh cs fall, so arm only once cs is seen high.
  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      flush_sr <= '0;
      cs_armed <= 1'b0;
    end else begin
      flush_sr <= {flush_sr[P_SYNC_STAGES-1:0], 1'b1};
      if (flush_sr[P_SYNC_STAGES] && cs_lvl) cs_armed <= 1'b1;
    end
  end

  // Next-state, shift and word-completion decode; cs events override sampling.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    commit      = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && cs_armed) begin
          state_nxt   = RECV;
          bit_cnt_nxt = '0;
          shift_nxt   = '0;
        end
      end
      RECV: begin
        if (cs_rise) begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
          ferr_nxt    = (bit_cnt != '0);
        end else if (sample) begin
          shift_nxt = {shift_reg[P_DATA_WIDTH-2:0], mosi_lvl};
          if (bit_cnt == CNT_W'(P_DATA_WIDTH - 1)) begin
            commit      = 1'b1;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Receiver state, bit counter and shift register.
  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
    end
  end

  // Holding register: accept new words when empty or draining, else drop and flag.
  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= ferr_nxt;
      if (commit) begin
        if (!m_valid || m_ready) begin
          m_data  <= shift_nxt;
          m_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == RECV);

endmodule
